// File: rtl/usb_token_scheduler.sv
// rtl/usb_token_scheduler.sv - USB host token scheduler (SOF + two request channels)
//
// Purpose: picks the next token for the token generator. A pending SOF always
// wins. Otherwise one of two channels is chosen round-robin, but only while
// enough of the current (micro)frame remains.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   speed                           2'b10 high-speed, anything else full-speed
//   sof_req, sof_frame              SOF request pulse and its frame number
//   chN_req/type/addr/endp (N=0,1)  channel token requests, held until granted
//   chN_gnt, chN_done               grant pulse on issue, completion pulse
//   token_start/type/addr/endp/frame  command to the token generator
//   token_ready, token_done         token generator status
//   sof_overrun, timeout_err, busy  error pulses and activity flag
module usb_token_scheduler #(
  parameter int FS_FRAME_CYCLES = 60000,
  parameter int HS_FRAME_CYCLES = 7500,
  parameter int GUARD_CYCLES    = 600,
  parameter int DONE_TIMEOUT    = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  speed,
  input  logic        sof_req,
  input  logic [10:0] sof_frame,
  input  logic        ch0_req,
  input  logic [1:0]  ch0_type,
  input  logic [6:0]  ch0_addr,
  input  logic [3:0]  ch0_endp,
  input  logic        ch1_req,
  input  logic [1:0]  ch1_type,
  input  logic [6:0]  ch1_addr,
  input  logic [3:0]  ch1_endp,
  output logic        ch0_gnt,
  output logic        ch0_done,
  output logic        ch1_gnt,
  output logic        ch1_done,
  output logic        token_start,
  output logic [1:0]  token_type,
  output logic [6:0]  token_addr,
  output logic [3:0]  token_endp,
  output logic [10:0] token_frame,
  input  logic        token_ready,
  input  logic        token_done,
  output logic        sof_overrun,
  output logic        timeout_err,
  output logic        busy
);

  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  localparam logic [15:0] FS_LOAD = 16'(FS_FRAME_CYCLES - 1);
  localparam logic [15:0] HS_LOAD = 16'(HS_FRAME_CYCLES - 1);
  localparam logic [15:0] GUARD   = 16'(GUARD_CYCLES);
  localparam logic [TW-1:0] WAIT_LAST = TW'(DONE_TIMEOUT - 1);
  localparam logic [1:0] TYPE_SOF = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE} state_e;

  state_e        state_q, state_d;
  logic          sof_pending_q, sof_pending_d;
  logic [10:0]   sof_frame_q, sof_frame_d;
  logic [15:0]   frame_remain_q, frame_remain_d;
  logic          last_grant_q, last_grant_d;
  logic          sel_sof_q, sel_sof_d;
  logic          sel_ch_q, sel_ch_d;
  logic [1:0]    type_q, type_d;
  logic [6:0]    addr_q, addr_d;
  logic [3:0]    endp_q, endp_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          pick;
  logic          issue, issue_sof, in_wait;

  // The SOF code is not a legal channel token; it goes out as OUT.
  function automatic logic [1:0] chan_type(input logic [1:0] t);
    return (t == TYPE_SOF) ? 2'b00 : t;
  endfunction

  assign issue     = (state_q == S_ISSUE);
  assign issue_sof = issue && sel_sof_q;
  assign in_wait   = (state_q == S_WAIT_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      sof_pending_q  <= 1'b0;
      sof_frame_q    <= '0;
      frame_remain_q <= '0;
      last_grant_q   <= 1'b1;  // pretend ch1 went last so ch0 wins first
      sel_sof_q      <= 1'b0;
      sel_ch_q       <= 1'b0;
      type_q         <= '0;
      addr_q         <= '0;
      endp_q         <= '0;
      wait_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      sof_pending_q  <= sof_pending_d;
      sof_frame_q    <= sof_frame_d;
      frame_remain_q <= frame_remain_d;
      last_grant_q   <= last_grant_d;
      sel_sof_q      <= sel_sof_d;
      sel_ch_q       <= sel_ch_d;
      type_q         <= type_d;
      addr_q         <= addr_d;
      endp_q         <= endp_d;
      wait_cnt_q     <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sel_sof_d    = sel_sof_q;
    sel_ch_d     = sel_ch_q;
    type_d       = type_q;
    addr_d       = addr_q;
    endp_d       = endp_q;
    wait_cnt_d   = wait_cnt_q;
    timeout_err  = 1'b0;
    pick         = 1'b0;

    // A new request in the clearing cycle wins over the clear.
    sof_pending_d = sof_pending_q;
    sof_frame_d   = sof_frame_q;
    if (issue_sof) sof_pending_d = 1'b0;
    if (sof_req) begin
      sof_pending_d = 1'b1;
      sof_frame_d   = sof_frame;
    end

    frame_remain_d = (frame_remain_q != 16'd0) ? frame_remain_q - 16'd1 : 16'd0;
    if (issue_sof) frame_remain_d = (speed == 2'b10) ? HS_LOAD : FS_LOAD;

    case (state_q)
      S_IDLE: begin
        if (token_ready) begin
          if (sof_pending_q) begin
            state_d   = S_ISSUE;
            sel_sof_d = 1'b1;
            type_d    = TYPE_SOF;
            addr_d    = '0;
            endp_d    = '0;
          end else if ((frame_remain_q >= GUARD) && (ch0_req || ch1_req)) begin
            pick      = (ch0_req && ch1_req) ? ~last_grant_q : ch1_req;
            state_d   = S_ISSUE;
            sel_sof_d = 1'b0;
            sel_ch_d  = pick;
            type_d    = chan_type(pick ? ch1_type : ch0_type);
            addr_d    = pick ? ch1_addr : ch0_addr;
            endp_d    = pick ? ch1_endp : ch0_endp;
          end
        end
      end
      S_ISSUE: begin
        state_d    = S_WAIT_DONE;
        wait_cnt_d = '0;
        if (!sel_sof_q) last_grant_d = sel_ch_q;
      end
      S_WAIT_DONE: begin
        if (token_done) begin
          state_d = S_IDLE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_err = 1'b1;
          state_d     = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign token_start = issue;
  assign token_type  = issue ? type_q : 2'b00;
  assign token_addr  = issue ? addr_q : 7'd0;
  assign token_endp  = issue ? endp_q : 4'd0;
  // Read the latched frame live so a late overwrite before issue is honoured.
  assign token_frame = issue_sof ? sof_frame_q : 11'd0;

  assign ch0_gnt  = issue && !sel_sof_q && !sel_ch_q;
  assign ch1_gnt  = issue && !sel_sof_q &&  sel_ch_q;
  assign ch0_done = in_wait && token_done && !sel_sof_q && !sel_ch_q;
  assign ch1_done = in_wait && token_done && !sel_sof_q &&  sel_ch_q;

  assign sof_overrun = sof_req && sof_pending_q && !issue_sof;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_usb_token_scheduler.sv
// tb/tb_usb_token_scheduler.sv - self-checking bench for usb_token_scheduler
module tb_usb_token_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  speed = 2'b01;
  logic        sof_req = 1'b0;
  logic [10:0] sof_frame = '0;
  logic        ch0_req = 1'b0, ch1_req = 1'b0;
  logic [1:0]  ch0_type = '0, ch1_type = '0;
  logic [6:0]  ch0_addr = '0, ch1_addr = '0;
  logic [3:0]  ch0_endp = '0, ch1_endp = '0;
  logic        ch0_gnt, ch0_done, ch1_gnt, ch1_done;
  logic        token_start;
  logic [1:0]  token_type;
  logic [6:0]  token_addr;
  logic [3:0]  token_endp;
  logic [10:0] token_frame;
  logic        token_ready = 1'b1, token_done = 1'b0;
  logic        sof_overrun, timeout_err, busy;

  usb_token_scheduler dut (
    .clk(clk), .rst_n(rst_n), .speed(speed),
    .sof_req(sof_req), .sof_frame(sof_frame),
    .ch0_req(ch0_req), .ch0_type(ch0_type), .ch0_addr(ch0_addr), .ch0_endp(ch0_endp),
    .ch1_req(ch1_req), .ch1_type(ch1_type), .ch1_addr(ch1_addr), .ch1_endp(ch1_endp),
    .ch0_gnt(ch0_gnt), .ch0_done(ch0_done), .ch1_gnt(ch1_gnt), .ch1_done(ch1_done),
    .token_start(token_start), .token_type(token_type), .token_addr(token_addr),
    .token_endp(token_endp), .token_frame(token_frame),
    .token_ready(token_ready), .token_done(token_done),
    .sof_overrun(sof_overrun), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int failed = 0;
  int last_ch = 1;
  logic [1:0] r_type [2];
  logic [6:0] r_addr [2];
  logic [3:0] r_endp [2];

  // Reference frame budget: reloaded on every SOF issue, else counts to 0.
  logic [15:0] rem_m;
  logic        st_sof = 1'b0;
  logic [1:0]  st_speed = 2'b01;
  always @(negedge clk) begin
    st_sof   = token_start && (token_type == 2'b10);
    st_speed = speed;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rem_m <= 16'd0;
    else if (st_sof) rem_m <= (st_speed == 2'b10) ? 16'd7499 : 16'd59999;
    else if (rem_m != 16'd0) rem_m <= rem_m - 16'd1;
  end

  initial begin
    #700_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] exp_type(input logic [1:0] t);
    return (t == 2'b10) ? 2'b00 : t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {token_start, ch0_gnt, ch1_gnt, ch0_done, ch1_done, sof_overrun,
              timeout_err, busy, token_type, token_addr, token_endp, token_frame}, 32'd0);
  endtask

  task automatic raise(input int ch);
    r_type[ch] = 2'($urandom_range(0, 3));
    r_addr[ch] = 7'($urandom_range(0, 127));
    r_endp[ch] = 4'($urandom_range(0, 15));
    if (ch == 0) begin
      ch0_req = 1'b1; ch0_type = r_type[0]; ch0_addr = r_addr[0]; ch0_endp = r_endp[0];
    end else begin
      ch1_req = 1'b1; ch1_type = r_type[1]; ch1_addr = r_addr[1]; ch1_endp = r_endp[1];
    end
  endtask

  task automatic wait_start(input int maxc, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (token_start) begin ok = 1'b1; break; end
    end
    if (!ok) chk({tag, "_start_timeout"}, 32'd0, 32'd1);
  endtask

  // Called at the issue negedge; completes the token after a random latency.
  task automatic finish_tok(input int ch);
    int lat;
    lat = $urandom_range(0, 4);
    @(negedge clk);
    sof_req = 1'b0;
    repeat (lat) @(negedge clk);
    token_done = 1'b1;
    #1;
    chk("done_pulse", {30'd0, ch1_done, ch0_done}, (ch == 0) ? 32'd1 : (ch == 1) ? 32'd2 : 32'd0);
    @(negedge clk);
    token_done = 1'b0;
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_chan(input int ch, input string tag);
    chk({tag, "_gnt"}, {30'd0, ch1_gnt, ch0_gnt}, (ch == 0) ? 32'd1 : 32'd2);
    chk({tag, "_fields"}, {11'd0, token_type, token_addr, token_endp, token_frame},
        {11'd0, exp_type(r_type[ch]), r_addr[ch], r_endp[ch], 11'd0});
    if (ch == 0) ch0_req = 1'b0; else ch1_req = 1'b0;
    last_ch = ch;
  endtask

  task automatic serve(input int ch, input string tag);
    wait_start(20, tag);
    check_chan(ch, tag);
    finish_tok(ch);
  endtask

  task automatic check_sof(input logic [10:0] fr, input string tag);
    chk({tag, "_sof"}, {token_start, ch0_gnt, ch1_gnt, token_type, token_addr, token_endp, token_frame},
        {1'b1, 1'b0, 1'b0, 2'b10, 7'd0, 4'd0, fr});
  endtask

  task automatic pulse_sof(input logic [10:0] fr);
    sof_req = 1'b1; sof_frame = fr;
    @(negedge clk);
    sof_req = 1'b0;
  endtask

  task automatic wait_rem(input logic [15:0] v);
    bit ok = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (rem_m == v) begin ok = 1'b1; break; end
    end
    chk("rem_reached", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    int n;
    int k;
    repeat (3) @(negedge clk);
    chk_zero("reset_outs");
    rst_n = 1'b1;

    // Channels are blocked until the first SOF loads the frame budget.
    raise(0);
    n = 0;
    repeat (10) begin @(negedge clk); if (token_start) n++; end
    chk("blocked_before_sof", n, 0);
    ch0_req = 1'b0;

    // SOF latency: start two cycles after the request.
    sof_req = 1'b1; sof_frame = 11'd5;
    @(negedge clk);
    sof_req = 1'b0;
    chk("sof_lat1", {31'd0, token_start}, 32'd0);
    @(negedge clk);
    check_sof(11'd5, "sof5");
    finish_tok(-1);

    // token_done while idle is ignored.
    token_done = 1'b1;
    #1;
    chk("done_idle_ignored", {30'd0, ch1_done, ch0_done}, 32'd0);
    @(negedge clk);
    token_done = 1'b0;
    chk("idle_stays", {31'd0, busy}, 32'd0);

    // Both channels contend: strict alternation starting with ch0.
    raise(0); raise(1);
    for (int i = 0; i < 4; i++) begin
      serve(i % 2, "rr");
      if (i < 3) raise(i % 2);
    end
    ch0_req = 1'b0; ch1_req = 1'b0;

    // Randomized request mix against the round-robin rule.
    for (int i = 0; i < 16; i++) begin
      int exp_ch;
      if (!ch0_req && $urandom_range(0, 1) == 1) raise(0);
      if (!ch1_req && $urandom_range(0, 1) == 1) raise(1);
      if (!ch0_req && !ch1_req) raise(int'($urandom_range(0, 1)));
      if (ch0_req && ch1_req) exp_ch = (last_ch == 0) ? 1 : 0;
      else exp_ch = ch0_req ? 0 : 1;
      serve(exp_ch, "rand");
    end
    ch0_req = 1'b0; ch1_req = 1'b0;

    // Two SOF requests while busy: one overrun, the later frame is issued.
    raise(0);
    wait_start(20, "ovr_ch");
    check_chan(0, "ovr_ch");
    @(negedge clk);
    sof_req = 1'b1; sof_frame = 11'd7;
    #1 chk("ovr_first", {31'd0, sof_overrun}, 32'd0);
    @(negedge clk);
    sof_frame = 11'd8;
    #1 chk("ovr_second", {31'd0, sof_overrun}, 32'd1);
    @(negedge clk);
    sof_req = 1'b0;
    #1 chk("ovr_after", {30'd0, sof_overrun, busy}, 32'd1);
    token_done = 1'b1;
    #1 chk("ovr_ch_done", {30'd0, ch1_done, ch0_done}, 32'd1);
    @(negedge clk);
    token_done = 1'b0;
    wait_start(20, "sof8");
    check_sof(11'd8, "sof8");
    // New request in the clearing cycle re-arms without an overrun.
    sof_req = 1'b1; sof_frame = 11'd9;
    #1 chk("rearm_no_ovr", {31'd0, sof_overrun}, 32'd0);
    finish_tok(-1);
    wait_start(20, "sof9");
    check_sof(11'd9, "sof9");
    finish_tok(-1);

    // Withheld token_done times out after exactly DONE_TIMEOUT cycles.
    raise(1);
    wait_start(20, "to_ch");
    check_chan(1, "to_ch");
    k = 0;
    for (int i = 1; i <= 1100; i++) begin
      @(negedge clk);
      if (timeout_err) begin k = i; break; end
    end
    chk("timeout_cycles", k, 1023);
    chk("timeout_no_done", {30'd0, ch1_done, ch0_done}, 32'd0);
    @(negedge clk);
    chk("timeout_idle", {30'd0, timeout_err, busy}, 32'd0);
    raise(0);
    serve(0, "after_to");

    // High-speed guard window boundary.
    speed = 2'b10;
    pulse_sof(11'd20);
    wait_start(20, "sof20");
    check_sof(11'd20, "sof20");
    finish_tok(-1);
    wait_rem(16'd600);
    raise(0);
    @(negedge clk);
    chk("guard600_start", {31'd0, token_start}, 32'd1);
    check_chan(0, "guard600");
    finish_tok(0);

    pulse_sof(11'd21);
    wait_start(20, "sof21");
    check_sof(11'd21, "sof21");
    finish_tok(-1);
    wait_rem(16'd599);
    raise(0);
    n = 0;
    repeat (50) begin @(negedge clk); if (token_start) n++; end
    chk("guard599_blocked", n, 0);
    pulse_sof(11'd22);
    wait_start(20, "sof22");
    check_sof(11'd22, "sof22");
    finish_tok(-1);
    serve(0, "after_guard");

    // Reset in WAIT_DONE aborts silently.
    raise(1);
    wait_start(20, "rst_ch");
    check_chan(1, "rst_ch");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    last_ch = 1;
    token_done = 1'b1;
    #1 chk("rst_no_done", {30'd0, ch1_done, ch0_done}, 32'd0);
    @(negedge clk);
    token_done = 1'b0;
    chk("rst_idle", {30'd0, timeout_err, busy}, 32'd0);
    raise(0);
    n = 0;
    repeat (20) begin @(negedge clk); if (token_start) n++; end
    chk("blocked_after_reset", n, 0);
    ch0_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
